seq_div32: RTL and testbench
============================

SEQ_DIV32 -- requirements
Module: seq_div32

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 Port clk_i, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-004 Port start_i, input, 1 bit: request a division; sampled only in IDLE.
REQ-005 Port dividend_i, input, WIDTH bits: unsigned dividend; captured when start is accepted.
REQ-006 Port divisor_i, input, WIDTH bits: unsigned divisor; captured when start is accepted.
REQ-007 Port busy_o, output, 1 bit: high in every state except IDLE.
REQ-008 Port done_o, output, 1 bit: single-cycle completion pulse.
REQ-009 Port quotient_o, output, WIDTH bits: registered quotient.
REQ-010 Port remainder_o, output, WIDTH bits: registered remainder.
REQ-011 Port div_zero_o, output, 1 bit: registered flag, high when the last completed operation had a zero divisor.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 IDLE with start_i=1 and divisor_i!=0 SHALL behave as follows at the edge:
- capture both operands;
- clear the partial remainder;
- clear the iteration counter;
- go to RUN.
REQ-014 IDLE with start_i=1 and divisor_i==0 SHALL go directly to DONE at that edge, with:
- quotient_o = all ones;
- remainder_o = dividend_i;
- div_zero_o = 1.
REQ-015 Each RUN edge SHALL perform one restoring step:
- shift the partial remainder left one bit, shifting in the current dividend MSB;
- compute a trial value = shifted remainder minus divisor, at WIDTH+1 bits so there is no overflow;
- if the trial value is non-negative, keep it and shift 1 into the quotient LSB;
- otherwise keep the shifted remainder and shift 0 into the quotient LSB.
REQ-016 RUN SHALL last exactly WIDTH edges; on the WIDTH-th edge the FSM SHALL go to DONE and load quotient_o and remainder_o with the final values, and clear div_zero_o.
REQ-017 done_o SHALL be high only while in DONE, i.e. one cycle, WIDTH+1 edges after the accepting edge (one edge for a zero divisor).
REQ-018 DONE SHALL go to IDLE unconditionally on the next edge; start_i asserted in DONE SHALL be ignored.
REQ-019 start_i asserted in RUN or DONE SHALL be ignored, with no effect on the operation in progress.
REQ-020 A new start SHALL be accepted in IDLE on the cycle directly after DONE.
REQ-021 quotient_o, remainder_o and div_zero_o SHALL hold their values until the next completion, and SHALL not change during RUN.
REQ-022 Operand input changes after the accepting edge SHALL not affect the result.
REQ-023 Results SHALL satisfy dividend = quotient*divisor + remainder, with remainder < divisor, for every non-zero divisor, including:
- dividend < divisor gives quotient 0, remainder = dividend;
- dividend = 0 gives quotient 0, remainder 0.
REQ-024 The trial subtraction SHALL be implemented as an addition with the divisor inverted and carry-in 1.

Reset
REQ-025 rst_i=1 at an edge SHALL put the FSM in IDLE and clear:
- the iteration counter;
- busy_o and done_o;
- quotient_o, remainder_o and div_zero_o.
REQ-026 Reset SHALL take priority over start_i and over any in-progress RUN or DONE state.
REQ-027 An aborted operation SHALL never produce a done_o pulse or a result update.
REQ-028 start_i held high during reset SHALL be accepted on the first edge after rst_i falls.

Verification
REQ-029 The bench SHALL check: dividend 100, divisor 7, start for one cycle -> busy_o high for 33 cycles, done_o high 33 edges after start, quotient_o 14, remainder_o 2, div_zero_o 0.
REQ-030 The bench SHALL check: dividend 0x12345678, divisor 0 -> done_o on the next cycle, quotient_o 0xFFFFFFFF, remainder_o 0x12345678, div_zero_o 1.
REQ-031 The bench SHALL check: 0xFFFFFFFF / 1 -> quotient 0xFFFFFFFF, remainder 0. Then 5 / 9 -> quotient 0, remainder 5, with no idle gap between the two operations.
REQ-032 The bench SHALL check: start 100/7, then start 50/5 with new operands while busy -> second request ignored; result stays 14 r 2; exactly one done_o pulse.
REQ-033 The bench SHALL check: start 100/7, rst_i at cycle 10 for one cycle -> all outputs 0, no done_o. Then 9/3 -> quotient 3, remainder 0.
REQ-034 The bench SHALL run a random regression of at least 10,000 operand pairs, including 0 and all ones, checking REQ-023 and the latency in REQ-017.

Source files
------------

// File: rtl/seq_div32.sv
// Restoring sequential divider: done_o WIDTH+1 edges after accept (1 edge for a zero divisor).
// No backpressure: start_i is only honoured in IDLE; results hold until the next completion.
module seq_div32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_zero_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;

  logic             accept;
  logic             zero_div;
  logic             last_step;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             qbit;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;

  assign accept    = (state == IDLE) && start_i;
  assign zero_div  = (divisor_i == '0);
  assign last_step = (state == RUN) && (cnt == LAST_STEP);

  // dvd_q doubles as the quotient shift register: dividend bits leave at the
  // top while quotient bits enter at the bottom.
  assign shifted = {rem_q, dvd_q[WIDTH-1]};
  assign trial   = shifted + {1'b1, ~dvs_q} + {{WIDTH{1'b0}}, 1'b1};
  assign qbit    = ~trial[WIDTH];
  assign rem_nxt = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_nxt = {dvd_q[WIDTH-2:0], qbit};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_i) begin
          state_nxt = zero_div ? DONE : RUN;
        end
      end
      RUN: begin
        if (cnt == LAST_STEP) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state != IDLE);
    done_o = (state == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt         <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quotient_o  <= '0;
      remainder_o <= '0;
      div_zero_o  <= 1'b0;
    end else begin
      if (accept && !zero_div) begin
        dvd_q <= dividend_i;
        dvs_q <= divisor_i;
        rem_q <= '0;
        cnt   <= '0;
      end
      if (accept && zero_div) begin
        quotient_o  <= '1;
        remainder_o <= dividend_i;
        div_zero_o  <= 1'b1;
      end
      if (state == RUN) begin
        rem_q <= rem_nxt;
        dvd_q <= quo_nxt;
        cnt   <= cnt + CW'(1);
      end
      if (last_step) begin
        quotient_o  <= quo_nxt;
        remainder_o <= rem_nxt;
        div_zero_o  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_div32.sv
// Bench for seq_div32: directed table, multi-cycle corner sequences, and parallel random lanes.
module tb_seq_div32;

  localparam int NL  = 10;
  localparam int OPS = 1000;
  localparam int W   = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  dvd, dvs;
  logic          busy, done, dz;
  logic [W-1:0]  q, r;

  int n_vec = 0;
  int n_bad = 0;
  bit rand_go = 1'b0;
  int lanes_done = 0;

  always #5 clk = ~clk;

  seq_div32 #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .dividend_i(dvd), .divisor_i(dvs),
    .busy_o(busy), .done_o(done),
    .quotient_o(q), .remainder_o(r), .div_zero_o(dz)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called at the negedge just after the accepting edge; returns at the negedge showing done.
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 1;
    bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    if (busy) bcnt++;
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat, output int bcnt);
    @(negedge clk);
    start = 1'b1; dvd = a; dvs = b;
    @(negedge clk);
    start = 1'b0; dvd = $urandom; dvs = $urandom;
    wait_done(lat, bcnt);
  endtask

  typedef struct {
    logic [W-1:0] a, b, q, r;
    logic         dz;
    int           lat;
    int           bsy;
  } vec_t;

  vec_t tbl[11];

  // ---------------- random lanes: independent DUTs against plain / and % ----------------
  logic         l_start [NL];
  logic [W-1:0] l_a [NL], l_b [NL], l_q [NL], l_r [NL];
  logic         l_busy [NL], l_done [NL], l_dz [NL];

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    v = $urandom;
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return 1;
      3: return W'($urandom_range(0, 15));
      4: return v >> $urandom_range(0, 31);
      default: return v;
    endcase
  endfunction

  for (genvar g = 0; g < NL; g++) begin : g_lane
    seq_div32 #(.WIDTH(W)) u_div (
      .clk_i(clk), .rst_i(rst), .start_i(l_start[g]),
      .dividend_i(l_a[g]), .divisor_i(l_b[g]),
      .busy_o(l_busy[g]), .done_o(l_done[g]),
      .quotient_o(l_q[g]), .remainder_o(l_r[g]), .div_zero_o(l_dz[g])
    );

    initial begin
      int lat;
      logic [W-1:0] a, b, eq, er, hq, hr;
      logic ez, hz;
      bit stable;
      l_start[g] = 1'b0; l_a[g] = '0; l_b[g] = '0;
      wait (rand_go);
      for (int i = 0; i < OPS; i++) begin
        a = pick();
        b = pick();
        if (b == 0) begin
          eq = '1; er = a; ez = 1'b1;
        end else begin
          eq = a / b; er = a % b; ez = 1'b0;
        end
        @(negedge clk);
        l_start[g] = 1'b1; l_a[g] = a; l_b[g] = b;
        @(negedge clk);
        hq = l_q[g]; hr = l_r[g]; hz = l_dz[g];
        stable = 1'b1;
        lat = 1;
        while (!l_done[g] && lat < 100) begin
          if (l_q[g] !== hq || l_r[g] !== hr || l_dz[g] !== hz) stable = 1'b0;
          // noise on start and operands while the operation runs must be ignored
          l_start[g] = 1'($urandom_range(0, 1));
          l_a[g] = $urandom;
          l_b[g] = $urandom;
          @(negedge clk);
          lat++;
        end
        check("rand_latency", 64'(lat), (b == 0) ? 64'd1 : 64'(W + 1));
        check("rand_quotient", 64'(l_q[g]), 64'(eq));
        check("rand_remainder", 64'(l_r[g]), 64'(er));
        check("rand_div_zero", 64'(l_dz[g]), 64'(ez));
        check("rand_hold_in_run", 64'(stable), 64'd1);
        l_start[g] = 1'b0;
      end
      lanes_done++;
    end
  end

  // ---------------- directed flow ----------------
  initial begin
    int lat, bcnt, dcnt, cyc;

    tbl[0]  = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33, 33};
    tbl[1]  = '{32'h12345678,   32'd0,          32'hFFFFFFFF,   32'h12345678,   1'b1, 1,  1};
    tbl[2]  = '{32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0, 33, 33};
    tbl[3]  = '{32'd5,          32'd9,          32'd0,          32'd5,          1'b0, 33, 33};
    tbl[4]  = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0, 33, 33};
    tbl[5]  = '{32'd0,          32'd0,          32'hFFFFFFFF,   32'd0,          1'b1, 1,  1};
    tbl[6]  = '{32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,          1'b0, 33, 33};
    tbl[7]  = '{32'h80000000,   32'd3,          32'h2AAAAAAA,   32'd2,          1'b0, 33, 33};
    tbl[8]  = '{32'hFFFFFFFE,   32'hFFFFFFFF,   32'd0,          32'hFFFFFFFE,   1'b0, 33, 33};
    tbl[9]  = '{32'hDEADBEEF,   32'h00010000,   32'h0000DEAD,   32'h0000BEEF,   1'b0, 33, 33};
    tbl[10] = '{32'd1000000,    32'd1000,       32'd1000,       32'd0,          1'b0, 33, 33};

    rst = 1'b1; start = 1'b0; dvd = '0; dvs = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_quotient", 64'(q), 64'd0);
    check("reset_remainder", 64'(r), 64'd0);
    check("reset_div_zero", 64'(dz), 64'd0);
    rst = 1'b0;

    // back-to-back table: each start lands on the IDLE cycle right after DONE
    for (int i = 0; i < 11; i++) begin
      do_op(tbl[i].a, tbl[i].b, lat, bcnt);
      check("tbl_latency", 64'(lat), 64'(tbl[i].lat));
      check("tbl_busy_cycles", 64'(bcnt), 64'(tbl[i].bsy));
      check("tbl_quotient", 64'(q), 64'(tbl[i].q));
      check("tbl_remainder", 64'(r), 64'(tbl[i].r));
      check("tbl_div_zero", 64'(dz), 64'(tbl[i].dz));
    end
    @(negedge clk);
    check("done_single_cycle", 64'(done), 64'd0);

    // second start while busy (held into DONE) is ignored
    @(negedge clk);
    start = 1'b1; dvd = 32'd100; dvs = 32'd7;
    dcnt = 0;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      if (done) dcnt++;
      if (k >= 4 && k < 33) begin
        start = 1'b1; dvd = 32'd50; dvs = 32'd5;
      end else begin
        start = 1'b0;
      end
    end
    check("busy_start_done_pulses", 64'(dcnt), 64'd1);
    check("busy_start_quotient", 64'(q), 64'd14);
    check("busy_start_remainder", 64'(r), 64'd2);
    check("busy_start_idle_after", 64'(busy), 64'd0);

    // reset at cycle 10 of a running operation aborts it
    @(negedge clk);
    start = 1'b1; dvd = 32'd100; dvs = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_quotient", 64'(q), 64'd0);
    check("abort_remainder", 64'(r), 64'd0);
    check("abort_div_zero", 64'(dz), 64'd0);
    dcnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("abort_no_done", 64'(dcnt), 64'd0);
    check("abort_no_update", 64'(q), 64'd0);
    do_op(32'd9, 32'd3, lat, bcnt);
    check("after_abort_latency", 64'(lat), 64'd33);
    check("after_abort_quotient", 64'(q), 64'd3);
    check("after_abort_remainder", 64'(r), 64'd0);

    // start held through reset is taken on the first edge after release
    @(negedge clk);
    rst = 1'b1; start = 1'b1; dvd = 32'd200; dvs = 32'd9;
    repeat (2) @(negedge clk);
    check("rst_start_idle", 64'(busy), 64'd0);
    check("rst_start_cleared", 64'(q), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("rst_start_accepted", 64'(busy), 64'd1);
    wait_done(lat, bcnt);
    check("rst_start_latency", 64'(lat), 64'd33);
    check("rst_start_quotient", 64'(q), 64'd22);
    check("rst_start_remainder", 64'(r), 64'd2);

    rand_go = 1'b1;
    cyc = 0;
    while (lanes_done < NL && cyc < 80000) begin
      @(negedge clk);
      cyc++;
    end
    check("random_lanes_finished", 64'(lanes_done), 64'(NL));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
